// File: rtl/sram_slot_scheduler_if.sv
// Signal bundle between the SRAM slot scheduler, its video/host clients and the SRAM pins.
// The slave modport is the scheduler's view; the master modport is the surrounding system.
interface sram_slot_scheduler_if #(
   parameter int ADDR_WIDTH = 18,
   parameter int DATA_WIDTH = 16
);
   logic [2:0]            pixelClockPhase;
   logic                  videoReadReq;
   logic [ADDR_WIDTH-1:0] videoReadAddr;
   logic [DATA_WIDTH-1:0] videoReadData;
   logic                  videoReadValid;
   logic                  hostReq;
   logic                  hostWe;
   logic [ADDR_WIDTH-1:0] hostAddr;
   logic [DATA_WIDTH-1:0] hostWData;
   logic [DATA_WIDTH-1:0] hostRData;
   logic                  hostAck;
   logic [ADDR_WIDTH-1:0] sramAddr;
   logic [DATA_WIDTH-1:0] sramDataOut;
   logic                  sramDataOe;
   logic [DATA_WIDTH-1:0] sramDataIn;
   logic                  sramCe_n;
   logic                  sramOe_n;
   logic                  sramWe_n;
   logic                  phaseError;

   modport slave (
      input  pixelClockPhase, videoReadReq, videoReadAddr,
      input  hostReq, hostWe, hostAddr, hostWData, sramDataIn,
      output videoReadData, videoReadValid, hostRData, hostAck,
      output sramAddr, sramDataOut, sramDataOe, sramCe_n, sramOe_n, sramWe_n,
      output phaseError
   );

   modport master (
      output pixelClockPhase, videoReadReq, videoReadAddr,
      output hostReq, hostWe, hostAddr, hostWData, sramDataIn,
      input  videoReadData, videoReadValid, hostRData, hostAck,
      input  sramAddr, sramDataOut, sramDataOe, sramCe_n, sramOe_n, sramWe_n,
      input  phaseError
   );
endinterface

// File: rtl/sram_slot_scheduler.sv
// Time-slot SRAM scheduler: each 6-phase pixel period carries a fixed video read window
// (phases 0-2) and a host read/write window (phases 3-5), with turnaround cycles between
// them. A break in the phase sequence aborts the current access and latches phaseError.
module sram_slot_scheduler #(
   parameter int ADDR_WIDTH = 18,
   parameter int DATA_WIDTH = 16
) (
   input logic                  pixelClockX6,
   input logic                  nReset,
   sram_slot_scheduler_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      VID_RD,
      HOST_RD,
      HOST_WR_ASSERT,
      HOST_WR_HOLD
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_WIDTH-1:0] sram_dout_q, sram_dout_d;
   logic                  sram_doe_q, sram_doe_d;
   logic                  sram_ce_n_q, sram_ce_n_d;
   logic                  sram_oe_n_q, sram_oe_n_d;
   logic                  sram_we_n_q, sram_we_n_d;
   logic [DATA_WIDTH-1:0] video_data_q, video_data_d;
   logic                  video_valid_q, video_valid_d;
   logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
   logic                  host_ack_q, host_ack_d;
   logic                  phase_error_q, phase_error_d;
   logic [2:0]            prev_phase_q, prev_phase_d;
   logic                  ref_valid_q, ref_valid_d;

   logic [2:0] phase;
   logic [2:0] expected_phase;
   logic       phase_fault;

   assign phase          = bus.pixelClockPhase;
   assign expected_phase = (prev_phase_q == 3'd5) ? 3'd0 : prev_phase_q + 3'd1;
   // The first edge after reset only establishes the reference phase.
   assign phase_fault    = ref_valid_q && ((phase > 3'd5) || (phase != expected_phase));

   // Next-state and next-output logic for the slot FSM and the phase checker.
   always_comb begin
      state_d       = state_q;
      sram_addr_d   = sram_addr_q;
      sram_dout_d   = sram_dout_q;
      sram_doe_d    = sram_doe_q;
      sram_ce_n_d   = sram_ce_n_q;
      sram_oe_n_d   = sram_oe_n_q;
      sram_we_n_d   = sram_we_n_q;
      video_data_d  = video_data_q;
      video_valid_d = 1'b0;
      host_rdata_d  = host_rdata_q;
      host_ack_d    = 1'b0;
      phase_error_d = phase_error_q;
      prev_phase_d  = phase;
      ref_valid_d   = 1'b1;

      if (phase_fault) begin
         // Release the bus on the faulting edge; a pending host request simply
         // stays high and is picked up again at the next good phase-3 edge.
         phase_error_d = 1'b1;
         state_d       = IDLE;
         sram_ce_n_d   = 1'b1;
         sram_oe_n_d   = 1'b1;
         sram_we_n_d   = 1'b1;
         sram_doe_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (phase == 3'd0 && bus.videoReadReq) begin
                  state_d     = VID_RD;
                  sram_addr_d = bus.videoReadAddr;
                  sram_ce_n_d = 1'b0;
                  sram_oe_n_d = 1'b0;
               end else if (phase == 3'd3 && bus.hostReq) begin
                  sram_addr_d = bus.hostAddr;
                  sram_ce_n_d = 1'b0;
                  if (bus.hostWe) begin
                     state_d     = HOST_WR_ASSERT;
                     sram_dout_d = bus.hostWData;
                     sram_doe_d  = 1'b1;
                     sram_we_n_d = 1'b0;
                  end else begin
                     state_d     = HOST_RD;
                     sram_oe_n_d = 1'b0;
                  end
               end
            end
            VID_RD: begin
               if (phase == 3'd2) begin
                  state_d       = IDLE;
                  video_data_d  = bus.sramDataIn;
                  video_valid_d = 1'b1;
                  sram_ce_n_d   = 1'b1;
                  sram_oe_n_d   = 1'b1;
               end
            end
            HOST_WR_ASSERT: begin
               // Write edge on WE rising; address and data stay for one hold cycle.
               if (phase == 3'd4) begin
                  state_d     = HOST_WR_HOLD;
                  sram_we_n_d = 1'b1;
               end
            end
            HOST_RD, HOST_WR_HOLD: begin
               if (phase == 3'd5) begin
                  state_d     = IDLE;
                  sram_ce_n_d = 1'b1;
                  sram_oe_n_d = 1'b1;
                  sram_we_n_d = 1'b1;
                  sram_doe_d  = 1'b0;
                  host_ack_d  = 1'b1;
                  if (state_q == HOST_RD) begin
                     host_rdata_d = bus.sramDataIn;
                  end
               end
            end
            default: begin
               state_d     = IDLE;
               sram_ce_n_d = 1'b1;
               sram_oe_n_d = 1'b1;
               sram_we_n_d = 1'b1;
               sram_doe_d  = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs; reset releases the SRAM bus immediately.
   always_ff @(posedge pixelClockX6 or negedge nReset) begin
      if (!nReset) begin
         state_q       <= IDLE;
         sram_addr_q   <= '0;
         sram_dout_q   <= '0;
         sram_doe_q    <= 1'b0;
         sram_ce_n_q   <= 1'b1;
         sram_oe_n_q   <= 1'b1;
         sram_we_n_q   <= 1'b1;
         video_data_q  <= '0;
         video_valid_q <= 1'b0;
         host_rdata_q  <= '0;
         host_ack_q    <= 1'b0;
         phase_error_q <= 1'b0;
         prev_phase_q  <= 3'd0;
         ref_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sram_addr_q   <= sram_addr_d;
         sram_dout_q   <= sram_dout_d;
         sram_doe_q    <= sram_doe_d;
         sram_ce_n_q   <= sram_ce_n_d;
         sram_oe_n_q   <= sram_oe_n_d;
         sram_we_n_q   <= sram_we_n_d;
         video_data_q  <= video_data_d;
         video_valid_q <= video_valid_d;
         host_rdata_q  <= host_rdata_d;
         host_ack_q    <= host_ack_d;
         phase_error_q <= phase_error_d;
         prev_phase_q  <= prev_phase_d;
         ref_valid_q   <= ref_valid_d;
      end
   end

   assign bus.sramAddr       = sram_addr_q;
   assign bus.sramDataOut    = sram_dout_q;
   assign bus.sramDataOe     = sram_doe_q;
   assign bus.sramCe_n       = sram_ce_n_q;
   assign bus.sramOe_n       = sram_oe_n_q;
   assign bus.sramWe_n       = sram_we_n_q;
   assign bus.videoReadData  = video_data_q;
   assign bus.videoReadValid = video_valid_q;
   assign bus.hostRData      = host_rdata_q;
   assign bus.hostAck        = host_ack_q;
   assign bus.phaseError     = phase_error_q;

endmodule

// File: tb/tb_sram_slot_scheduler.sv
// Directed bench for sram_slot_scheduler: video slot, host write, host read interleaved
// with video, phase-jump abort/retry and asynchronous reset mid-access.
module tb_sram_slot_scheduler;
   localparam int AW = 18;
   localparam int DW = 16;
   localparam logic [AW-1:0] VID_ADDR = 18'h12345;

   logic       clk;
   logic       nReset;
   logic [2:0] phase;
   int         last_phase;
   int         checks;
   int         failures;
   int         wr_count;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   sram_slot_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   sram_slot_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .pixelClockX6 (clk),
      .nReset       (nReset),
      .bus          (bus)
   );

   assign bus.pixelClockPhase = phase;
   // SRAM read model: video address returns 0xBEEF, any other address 0xC0DE.
   assign bus.sramDataIn = (!bus.sramCe_n && !bus.sramOe_n)
                           ? ((bus.sramAddr == VID_ADDR) ? 16'hBEEF : 16'hC0DE) : 16'hDEAD;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record every cycle in which the SRAM sees an active write.
   initial wr_count = 0;
   always @(posedge clk) begin
      if (nReset && !bus.sramCe_n && !bus.sramWe_n && bus.sramDataOe) begin
         wr_count <= wr_count + 1;
         wr_addr  <= bus.sramAddr;
         wr_data  <= bus.sramDataOut;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      last_phase = int'(phase);
      phase = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
   endtask

   task automatic test_reset();
      nReset = 1'b0;
      phase = 3'd0;
      bus.videoReadReq = 1'b0;
      bus.videoReadAddr = '0;
      bus.hostReq = 1'b0;
      bus.hostWe = 1'b0;
      bus.hostAddr = '0;
      bus.hostWData = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe} !== 4'b1110) begin
         failures++;
         $display("FAIL reset_strobes: got %b expected 1110",
                  {bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe});
      end
      checks++;
      if ({bus.sramAddr, bus.sramDataOut, bus.videoReadData, bus.videoReadValid,
           bus.hostRData, bus.hostAck, bus.phaseError} !== '0) begin
         failures++;
         $display("FAIL reset_values: addr=%h dout=%h vdata=%h vvalid=%b hrdata=%h ack=%b perr=%b expected all 0",
                  bus.sramAddr, bus.sramDataOut, bus.videoReadData, bus.videoReadValid,
                  bus.hostRData, bus.hostAck, bus.phaseError);
      end
      nReset = 1'b1;
      $display("reset: released, phase reference starts at 0");
   endtask

   task automatic test_video();
      logic [3:0] exp_str;
      int valids;
      valids = 0;
      bus.videoReadReq = 1'b1;
      bus.videoReadAddr = VID_ADDR;
      for (int n = 0; n < 18; n++) begin
         tick();
         exp_str = (last_phase == 0 || last_phase == 1) ? 4'b0010 : 4'b1110;
         checks++;
         if ({bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe} !== exp_str) begin
            failures++;
            $display("FAIL video_strobes ph%0d: got %b expected %b", last_phase,
                     {bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe}, exp_str);
         end
         checks++;
         if (bus.videoReadValid !== (last_phase == 2)) begin
            failures++;
            $display("FAIL video_valid ph%0d: got %b expected %b", last_phase,
                     bus.videoReadValid, (last_phase == 2));
         end
         if (last_phase == 0) begin
            checks++;
            if (bus.sramAddr !== VID_ADDR) begin
               failures++;
               $display("FAIL video_addr: got %h expected %h", bus.sramAddr, VID_ADDR);
            end
         end
         if (last_phase == 2) begin
            valids++;
            checks++;
            if (bus.videoReadData !== 16'hBEEF) begin
               failures++;
               $display("FAIL video_data: got %h expected beef", bus.videoReadData);
            end
            $display("video read: addr=%h data=%h", VID_ADDR, bus.videoReadData);
         end
      end
      bus.videoReadReq = 1'b0;
      checks++;
      if (valids != 3 || bus.phaseError !== 1'b0) begin
         failures++;
         $display("FAIL video_summary: valids=%0d perr=%b expected 3 and 0", valids, bus.phaseError);
      end
   endtask

   task automatic test_host_write();
      logic [3:0] exp_str;
      int ack_n, we_low, oe_high, wr0;
      logic started;
      ack_n = 0; we_low = 0; oe_high = 0; started = 1'b0;
      bus.videoReadReq = 1'b0;
      for (int k = 0; k < 8 && last_phase != 4; k++) tick();
      wr0 = wr_count;
      bus.hostReq = 1'b1;
      bus.hostWe = 1'b1;
      bus.hostAddr = 18'h00010;
      bus.hostWData = 16'hA5A5;
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (last_phase == 3) started = 1'b1;
         exp_str = (started && last_phase == 3) ? 4'b0101 :
                   (started && last_phase == 4) ? 4'b0111 : 4'b1110;
         checks++;
         if ({bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe} !== exp_str) begin
            failures++;
            $display("FAIL hwr_strobes n=%0d ph%0d: got %b expected %b", n, last_phase,
                     {bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe}, exp_str);
         end
         if (!bus.sramWe_n) we_low++;
         if (bus.sramDataOe) oe_high++;
         if (started && last_phase == 3) begin
            checks++;
            if (bus.sramAddr !== 18'h00010 || bus.sramDataOut !== 16'hA5A5) begin
               failures++;
               $display("FAIL hwr_bus: addr=%h data=%h expected 00010 a5a5", bus.sramAddr, bus.sramDataOut);
            end
         end
         if (bus.hostAck) begin
            ack_n = n;
            break;
         end
      end
      bus.hostReq = 1'b0;
      $display("host write: addr=00010 data=a5a5 ack after %0d clocks", ack_n);
      checks++;
      if (ack_n != 7) begin
         failures++;
         $display("FAIL hwr_latency: got %0d expected 7", ack_n);
      end
      checks++;
      if (we_low != 1 || oe_high != 2) begin
         failures++;
         $display("FAIL hwr_pulses: we_low=%0d oe_high=%0d expected 1 and 2", we_low, oe_high);
      end
      checks++;
      if (wr_count - wr0 != 1 || wr_addr !== 18'h00010 || wr_data !== 16'hA5A5) begin
         failures++;
         $display("FAIL hwr_sram: writes=%0d addr=%h data=%h expected 1 00010 a5a5",
                  wr_count - wr0, wr_addr, wr_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_str;
      logic [AW-1:0] exp_addr;
      int acks, valids;
      acks = 0; valids = 0;
      for (int k = 0; k < 8 && last_phase != 5; k++) tick();
      bus.videoReadReq = 1'b1;
      bus.videoReadAddr = VID_ADDR;
      bus.hostReq = 1'b1;
      bus.hostWe = 1'b0;
      bus.hostAddr = 18'h00777;
      for (int n = 0; n < 18; n++) begin
         tick();
         exp_str = (last_phase == 2 || last_phase == 5) ? 4'b1110 : 4'b0010;
         exp_addr = (last_phase < 2) ? VID_ADDR : 18'h00777;
         checks++;
         if ({bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe} !== exp_str) begin
            failures++;
            $display("FAIL mix_strobes ph%0d: got %b expected %b", last_phase,
                     {bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe}, exp_str);
         end
         if (exp_str == 4'b0010) begin
            checks++;
            if (bus.sramAddr !== exp_addr) begin
               failures++;
               $display("FAIL mix_owner ph%0d: addr got %h expected %h", last_phase, bus.sramAddr, exp_addr);
            end
         end
         checks++;
         if (bus.hostAck !== (last_phase == 5) || bus.videoReadValid !== (last_phase == 2)) begin
            failures++;
            $display("FAIL mix_pulses ph%0d: ack=%b vvalid=%b expected %b %b", last_phase,
                     bus.hostAck, bus.videoReadValid, (last_phase == 5), (last_phase == 2));
         end
         if (bus.hostAck) begin
            acks++;
            checks++;
            if (bus.hostRData !== 16'hC0DE) begin
               failures++;
               $display("FAIL mix_rdata: got %h expected c0de", bus.hostRData);
            end
            $display("host read: addr=00777 data=%h", bus.hostRData);
         end
         if (bus.videoReadValid) valids++;
      end
      bus.hostReq = 1'b0;
      bus.videoReadReq = 1'b0;
      checks++;
      if (acks != 3 || valids != 3) begin
         failures++;
         $display("FAIL mix_counts: acks=%0d valids=%0d expected 3 3", acks, valids);
      end
   endtask

   task automatic test_phase_error();
      logic [3:0] exp_str;
      int wr0;
      logic got_ack;
      got_ack = 1'b0;
      for (int k = 0; k < 8 && last_phase != 2; k++) tick();
      wr0 = wr_count;
      bus.hostReq = 1'b1;
      bus.hostWe = 1'b1;
      bus.hostAddr = 18'h00020;
      bus.hostWData = 16'h5A5A;
      tick();
      checks++;
      if ({bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe, bus.phaseError} !== 5'b01010) begin
         failures++;
         $display("FAIL perr_start: got %b expected 01010",
                  {bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe, bus.phaseError});
      end
      phase = 3'd5;
      tick();
      checks++;
      if ({bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe, bus.hostAck, bus.phaseError} !== 6'b111001) begin
         failures++;
         $display("FAIL perr_abort: got %b expected 111001",
                  {bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe, bus.hostAck, bus.phaseError});
      end
      $display("phase jump 3->5: phaseError=%b", bus.phaseError);
      for (int n = 0; n < 8; n++) begin
         tick();
         exp_str = (last_phase == 3) ? 4'b0101 : (last_phase == 4) ? 4'b0111 : 4'b1110;
         checks++;
         if ({bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe} !== exp_str ||
             bus.hostAck !== (last_phase == 5) || bus.phaseError !== 1'b1) begin
            failures++;
            $display("FAIL perr_retry ph%0d: str=%b ack=%b perr=%b expected %b %b 1", last_phase,
                     {bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe},
                     bus.hostAck, bus.phaseError, exp_str, (last_phase == 5));
         end
         if (bus.hostAck) begin
            got_ack = 1'b1;
            break;
         end
      end
      bus.hostReq = 1'b0;
      $display("retried write: ack=%b writes=%0d", got_ack, wr_count - wr0);
      checks++;
      if (!got_ack || wr_count - wr0 != 2 || wr_addr !== 18'h00020 || wr_data !== 16'h5A5A) begin
         failures++;
         $display("FAIL perr_result: ack=%b writes=%0d addr=%h data=%h expected 1 2 00020 5a5a",
                  got_ack, wr_count - wr0, wr_addr, wr_data);
      end
   endtask

   task automatic test_async_reset();
      int valids;
      valids = 0;
      for (int k = 0; k < 8 && last_phase != 5; k++) tick();
      bus.videoReadReq = 1'b1;
      bus.videoReadAddr = VID_ADDR;
      tick();
      checks++;
      if ({bus.sramCe_n, bus.sramOe_n} !== 2'b00) begin
         failures++;
         $display("FAIL areset_pre: ce/oe got %b expected 00", {bus.sramCe_n, bus.sramOe_n});
      end
      #3;
      nReset = 1'b0;
      #1;
      checks++;
      if ({bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe, bus.videoReadValid,
           bus.phaseError} !== 6'b111000 || bus.videoReadData !== 16'h0000) begin
         failures++;
         $display("FAIL areset_now: got %b vdata=%h expected 111000 0000",
                  {bus.sramCe_n, bus.sramOe_n, bus.sramWe_n, bus.sramDataOe, bus.videoReadValid,
                   bus.phaseError}, bus.videoReadData);
      end
      @(posedge clk);
      #1;
      nReset = 1'b1;
      phase = 3'd4;
      $display("async reset mid video read, restart at phase 4");
      for (int n = 0; n < 8; n++) begin
         tick();
         checks++;
         if (bus.phaseError !== 1'b0 || bus.videoReadValid !== (last_phase == 2)) begin
            failures++;
            $display("FAIL areset_after ph%0d: perr=%b vvalid=%b expected 0 %b", last_phase,
                     bus.phaseError, bus.videoReadValid, (last_phase == 2));
         end
         if (bus.videoReadValid) valids++;
      end
      bus.videoReadReq = 1'b0;
      checks++;
      if (valids != 1 || bus.videoReadData !== 16'hBEEF) begin
         failures++;
         $display("FAIL areset_video: valids=%0d data=%h expected 1 beef", valids, bus.videoReadData);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      last_phase = 0;
      nReset = 1'b0;
      phase = 3'd0;
      test_reset();
      test_video();
      test_host_write();
      test_back_to_back();
      test_phase_error();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/sram_slot_scheduler.md
# sram_slot_scheduler

Time-slot SRAM access scheduler for the frame buffer, clocked by the x6 pixel clock. It uses the 0–5 pixel clock phase count to split every pixel period into two fixed SRAM windows. The first is a guaranteed video read window for the pixel output path; the second is a host read/write window with a req/ack handshake. The block also checks the phase sequence for continuity and releases the SRAM bus safely if the sequence breaks.

## Interface
- ADDR_WIDTH, 18, SRAM word address width
- DATA_WIDTH, 16, SRAM data width
- pixelClockX6  in  1  system clock (81.000 MHz, pixel clock x6); all logic on rising edge
- nReset  in  1  asynchronous, active-low reset
- pixelClockPhase  in  3  pixel phase count, legal values 0..5, increments by 1 each clock
- videoReadReq  in  1  video read request, sampled only on a phase-0 edge
- videoReadAddr  in  ADDR_WIDTH  video read address, sampled with videoReadReq
- videoReadData  out  DATA_WIDTH  video read result
- videoReadValid  out  1  one-cycle pulse; videoReadData is valid
- hostReq  in  1  host transaction request, held until hostAck
- hostWe  in  1  1 = write, 0 = read; stable while hostReq is high
- hostAddr  in  ADDR_WIDTH  host address; stable while hostReq is high
- hostWData  in  DATA_WIDTH  host write data; stable while hostReq is high
- hostRData  out  DATA_WIDTH  host read result, valid with hostAck
- hostAck  out  1  one-cycle completion pulse
- sramAddr  out  ADDR_WIDTH  SRAM address
- sramDataOut  out  DATA_WIDTH  SRAM write data
- sramDataOe  out  1  1 = drive the SRAM data bus (tristate control at top level)
- sramDataIn  in  DATA_WIDTH  SRAM read data
- sramCe_n, sramOe_n, sramWe_n  out  1 each  SRAM strobes, active low
- phaseError  out  1  sticky flag: phase sequence fault

## Operation
- Edge terminology: "phase-N edge" is the rising edge at which the sampled pixelClockPhase equals N. All outputs are registered and change just after that edge.
- States: IDLE, VID_RD, HOST_RD, HOST_WR_ASSERT, HOST_WR_HOLD.
- Video window (phase 0):
  - Phase-0 edge, videoReadReq=1, state IDLE → VID_RD: sramAddr←videoReadAddr, sramCe_n←0, sramOe_n←0.
  - Phase-0 edge with videoReadReq=0: the slot stays idle and is not given to the host.
  - Phase-2 edge in VID_RD → IDLE: videoReadData←sramDataIn, videoReadValid←1 for one cycle, sramCe_n←1, sramOe_n←1.
- Host window (phase 3):
  - Phase-3 edge, hostReq=1, state IDLE: latch hostAddr into sramAddr, sramCe_n←0.
  - Read: sramOe_n←0 → HOST_RD.
  - Write: sramDataOut←hostWData, sramDataOe←1, sramWe_n←0 → HOST_WR_ASSERT.
  - Phase-4 edge in HOST_WR_ASSERT: sramWe_n←1 (data and address held) → HOST_WR_HOLD.
  - Phase-5 edge in HOST_RD or HOST_WR_HOLD → IDLE: all strobes←1, sramDataOe←0, hostAck←1 for one cycle. For a read, also hostRData←sramDataIn.
  - If hostReq is still high at the next phase-3 edge, a new transaction starts. Maximum throughput is one host access per pixel.
- Bus turnaround: strobes are high and sramDataOe=0 for the full cycle after each phase-2 and phase-5 edge.
- Phase checking:
  - First edge after reset: no check; the sampled phase becomes the reference.
  - Every later edge: expected = (previous + 1) mod 6. A mismatch, or phase 6 or 7, sets phaseError and forces IDLE.
  - On that same edge, strobes go high and sramDataOe drops. No videoReadValid or hostAck is issued for the aborted access.
  - An aborted host request stays pending and is retried at the next valid phase-3 edge.
  - phaseError clears only on nReset.
- Reset values: sramAddr=0, sramDataOut=0, sramDataOe=0, sramCe_n=sramOe_n=sramWe_n=1, videoReadData=0, videoReadValid=0, hostRData=0, hostAck=0, phaseError=0, state IDLE. Assertion takes effect immediately (asynchronously), mid-access included.

## Timing
- Video read latency: phase-0 edge → videoReadValid after phase-2 edge (2 clocks, 24.7 ns SRAM access window).
- Host read: 2 clocks of sramOe_n low. Host write: sramWe_n low for 1 clock, then 1 clock of data/address hold.
- Host latency, hostReq rise → hostAck: 3 clocks minimum (request seen on a phase-3 edge), 8 clocks maximum.
- The two windows never overlap, so there is no arbitration conflict. Video access always wins its slot.

## Test plan
- Continuous phase 0..5, videoReadReq=1, addr 0x12345, sramDataIn=0xBEEF model → sramCe_n/sramOe_n low for exactly the 2 cycles after each phase-0 edge; videoReadValid pulses after each phase-2 edge; videoReadData=0xBEEF.
- Host write addr 0x00010, data 0xA5A5, raised at phase 4 → access starts at the next phase-3 edge; sramWe_n low for 1 cycle; sramDataOe high for 2 cycles; hostAck 1 cycle after the phase-5 edge; 7 clocks total.
- Host read held high alongside video reads → one host read per pixel; no cycle with both a video and a host strobe active; idle turnaround cycles present.
- Phase jumps 3→5 during a host write → phaseError=1; strobes high on that edge; no hostAck; write reissued at the next phase-3 edge; phaseError stays 1.
- nReset pulled low mid VID_RD → strobes high and videoReadValid=0 immediately; after release, the first phase is accepted as reference with no phaseError.
